csk_mp_add_seq: RTL and testbench

//  Multi-precision add/subtract sequencer that time-shares one CSK_sin_mux #(m=CHUNK)

---
 rtl/csk_mp_add_seq.sv | 184 ++++++++++++++++++
 tb/tb_csk_mp_add_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csk_mp_add_seq.sv
// rtl/csk_mp_add_seq.sv - multi-precision add/sub sequencer time-sharing one carry-skip slice adder
// Processes one CHUNK-bit slice per cycle, LSB first, with the inter-slice carry held in a flop.

module CSK_sin_mux #(
  parameter int m = 32
) (
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  input  logic         cin,
  output logic [m-1:0] s,
  output logic         cout
);
  localparam int NB = m / 4;

  logic       blk_c;
  logic       rip_c;
  logic [3:0] prop;

  // 4-bit ripple blocks; a fully propagating block forwards its carry-in through the skip mux
  always_comb begin
    blk_c = cin;
    rip_c = 1'b0;
    prop  = '0;
    s     = '0;
    for (int g = 0; g < NB; g++) begin
      prop  = a[4*g +: 4] ^ b[4*g +: 4];
      rip_c = blk_c;
      for (int i = 0; i < 4; i++) begin
        s[4*g+i] = prop[i] ^ rip_c;
        rip_c    = (a[4*g+i] & b[4*g+i]) | (prop[i] & rip_c);
      end
      blk_c = (&prop) ? blk_c : rip_c;
    end
    cout = blk_c;
  end
endmodule

module csk_mp_add_seq #(
  parameter int W     = 128,
  parameter int CHUNK = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);
  localparam int NCH = W / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((W % CHUNK) != 0 || (CHUNK % 4) != 0) begin : g_width_chk
    $error("csk_mp_add_seq: W must be a multiple of CHUNK and CHUNK a multiple of 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_co;
  logic             last;
  int               idx;

  assign idx  = int'(cnt_q) * CHUNK;
  assign sl_a = a_q[idx +: CHUNK];
  assign sl_b = b_q[idx +: CHUNK];
  assign last = (cnt_q == CW'(NCH - 1));

  CSK_sin_mux #(.m(CHUNK)) u_add (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_co)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // subtraction is a + ~b + 1, so the operand is inverted once at accept
          a_d        = a;
          b_d        = op_sub ? ~b : b;
          carry_d    = op_sub ? 1'b1 : cin;
          cnt_d      = '0;
          state_d    = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        sum_d[idx +: CHUNK] = sl_s;
        carry_d             = sl_co;
        cnt_d               = cnt_q + CW'(1);
        if (last) begin
          cnt_d       = '0;
          state_d     = S_DONE;
          cout_d      = sl_co;
          ovf_d       = (sl_a[CHUNK-1] == sl_b[CHUNK-1]) && (sl_s[CHUNK-1] != sl_a[CHUNK-1]);
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_csk_mp_add_seq.sv
// tb/tb_csk_mp_add_seq.sv - self-checking bench for csk_mp_add_seq against a W-bit arithmetic model
// Directed literal cases, handshake hold, mid-run reset, then randomized traffic.

module tb_csk_mp_add_seq;
  localparam int W     = 128;
  localparam int CHUNK = 32;
  localparam int NCH   = W / CHUNK;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csk_mp_add_seq #(.W(W), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  res_t exp_q[$];
  int   cyc     = 0;
  int   acc_t   = 0;
  int   n_acc   = 0;
  int   n_res   = 0;
  int   n_abort = 0;
  bit   mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Plain W-bit arithmetic: unsigned compare for borrow, sign rules for overflow
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, input logic ci);
    res_t       r;
    logic [W:0] t;
    if (sub) begin
      t    = {1'b0, x} - {1'b0, y};
      r.s  = t[W-1:0];
      r.co = (x >= y);
      r.ov = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    end else begin
      t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.s  = t[W-1:0];
      r.co = t[W];
      r.ov = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      res_t r;
      logic pend;
      pend = (exp_q.size() != 0);
      chk1("mon_in_ready", in_ready, !pend);
      chk1("mon_busy", busy, pend);
      chk1("mon_out_valid", out_valid, pend && ((cyc - acc_t) >= NCH));
      if (out_valid && pend) begin
        chkw("mon_sum", sum, exp_q[0].s);
        chk1("mon_cout", cout, exp_q[0].co);
        chk1("mon_ovf", ovf, exp_q[0].ov);
      end
      if (rst) begin
        n_abort += exp_q.size();
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && pend) begin
          void'(exp_q.pop_front());
          n_res++;
        end
        if (in_valid && in_ready) begin
          r = model(a, b, op_sub, cin);
          exp_q.push_back(r);
          acc_t = cyc + 1;
          n_acc++;
        end
      end
    end
  end

  task automatic wait_acc(output int t0);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk1("accept_timeout", in_ready, 1'b1);
    t0 = cyc + 1;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("result_timeout", out_valid, 1'b1);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        input logic icin, output logic [W-1:0] s, output logic co,
                        output logic ov, output int lat);
    int t0;
    a = ia; b = ib; op_sub = isub; cin = icin; in_valid = 1'b1;
    wait_acc(t0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ov();
    s = sum; co = cout; ov = ovf; lat = cyc - t0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {32'h0, {96{1'b1}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      4:       v = {1'b1, {(W-1){1'b0}}};
      5:       v = W'($urandom_range(0, 3));
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s, smax, smin, bnd;
    logic         co, ov;
    int           lat, t0, target, guard;
    smax = {1'b0, {(W-1){1'b1}}};
    smin = {1'b1, {(W-1){1'b0}}};
    bnd  = {32'h0, {96{1'b1}}};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_sum", sum, '0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_op('1, '0, 1'b0, 1'b1, s, co, ov, lat);
    chkw("t1_sum", s, '0);
    chk1("t1_cout", co, 1'b1);
    chk1("t1_ovf", ov, 1'b0);
    chki("t1_latency", lat, 4);

    run_op(W'(5), W'(7), 1'b1, 1'b0, s, co, ov, lat);
    chkw("t2a_sum", s, {{(W-2){1'b1}}, 2'b10});
    chk1("t2a_cout", co, 1'b0);
    chk1("t2a_ovf", ov, 1'b0);
    run_op(W'(7), W'(5), 1'b1, 1'b1, s, co, ov, lat);
    chkw("t2b_sum", s, W'(2));
    chk1("t2b_cout", co, 1'b1);
    chk1("t2b_ovf", ov, 1'b0);

    run_op(smax, W'(1), 1'b0, 1'b0, s, co, ov, lat);
    chkw("t3a_sum", s, smin);
    chk1("t3a_cout", co, 1'b0);
    chk1("t3a_ovf", ov, 1'b1);
    run_op(smin, W'(1), 1'b1, 1'b0, s, co, ov, lat);
    chkw("t3b_sum", s, smax);
    chk1("t3b_cout", co, 1'b1);
    chk1("t3b_ovf", ov, 1'b1);

    run_op(bnd, W'(1), 1'b0, 1'b0, s, co, ov, lat);
    chkw("bnd_add_sum", s, {32'h1, 96'h0});
    chk1("bnd_add_cout", co, 1'b0);
    run_op({32'h1, 96'h0}, W'(1), 1'b1, 1'b0, s, co, ov, lat);
    chkw("bnd_sub_sum", s, bnd);
    chk1("bnd_sub_cout", co, 1'b1);

    // Result held off while a second request waits on in_valid
    a = W'(100); b = W'(23); op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    wait_acc(t0);
    @(posedge clk); #1;
    a = W'(55); b = W'(66);
    wait_ov();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("t4_hold_valid", out_valid, 1'b1);
      chk1("t4_hold_in_ready", in_ready, 1'b0);
      chkw("t4_hold_sum", sum, W'(123));
      chk1("t4_hold_cout", cout, 1'b0);
      chk1("t4_hold_ovf", ovf, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("t4_idle_in_ready", in_ready, 1'b1);
    chk1("t4_idle_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("t4_next_busy", busy, 1'b1);
    wait_ov();
    chkw("t4_next_sum", sum, W'(121));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second RUN cycle
    a = W'(9); b = W'(9); op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    wait_acc(t0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("t5_in_ready", in_ready, 1'b1);
    chk1("t5_out_valid", out_valid, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    chkw("t5_sum", sum, '0);
    chk1("t5_cout", cout, 1'b0);
    chk1("t5_ovf", ovf, 1'b0);
    @(posedge clk); #1;
    run_op(W'(3), W'(4), 1'b0, 1'b0, s, co, ov, lat);
    chkw("t5_add_sum", s, W'(7));

    target = n_acc + 2000;
    guard  = 0;
    while (n_acc < target && guard < 40000) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = rnd_val();
      b         = rnd_val();
      op_sub    = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    chk1("rand_budget", (n_acc >= target), 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chki("drain_pending", exp_q.size(), 0);
    chki("results_vs_accepts", n_res + n_abort, n_acc);
    chki("aborted_ops", n_abort, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
